packet_traffic_gen: RTL

//  Self-test traffic source/sink for network apps (e.g. packet loopback). Generator drives numbered

---
 rtl/packet_traffic_gen_if.sv | 17 +
 rtl/packet_traffic_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_traffic_gen_if.sv
// rtl/packet_traffic_gen_if.sv - stream bundle (tdata/tkeep/tid/tdest/tlast/tvalid/tready) with master/slave views
interface packet_traffic_gen_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tid, tdest, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tid, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/packet_traffic_gen.sv
// rtl/packet_traffic_gen.sv - numbered-packet stream generator and pattern checker with saturating counters
module packet_traffic_gen #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int LEN_WIDTH       = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          i_start,
  input  logic [CNT_WIDTH-1:0]          i_num_packets,
  input  logic [LEN_WIDTH-1:0]          i_pkt_beats,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   i_last_keep,
  input  logic [7:0]                    i_gap_cycles,
  input  logic [AXIS_DEST_WIDTH-1:0]    i_cfg_tdest,
  output logic                          o_busy,
  output logic                          o_done,
  packet_traffic_gen_if.master          gen,
  packet_traffic_gen_if.slave           chk,
  output logic [CNT_WIDTH-1:0]          o_tx_pkt_count,
  output logic [CNT_WIDTH-1:0]          o_rx_pkt_count,
  output logic [CNT_WIDTH-1:0]          o_rx_drop_count,
  output logic [CNT_WIDTH-1:0]          o_rx_err_count
);
  localparam int W  = AXIS_BUS_WIDTH;
  localparam int KW = W / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // Only the low 32 bits carry the pattern; everything above must be zero.
  localparam logic [W-1:0] LOW_MASK = W'(32'hFFFF_FFFF);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // Beat b of packet p carries {p[15:0], b[15:0]} in the low word.
  function automatic logic [W-1:0] f_pattern(input logic [15:0] pkt, input logic [15:0] beat);
    f_pattern = '0;
    f_pattern[31:0] = {pkt, beat};
  endfunction

  function automatic logic [KW-1:0] f_keep(input logic is_last, input logic [KW-1:0] last_keep);
    f_keep = is_last ? last_keep : '1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
    f_sat_inc = (&v) ? v : v + CNT_ONE;
  endfunction

  // Generator state
  state_t                     r_state;
  logic [CNT_WIDTH-1:0]       r_num;
  logic [CNT_WIDTH-1:0]       r_pkt;
  logic [15:0]                r_beats;
  logic [15:0]                r_beat;
  logic [KW-1:0]              r_last_keep;
  logic [7:0]                 r_gap;
  logic [7:0]                 r_gap_cnt;
  logic [AXIS_DEST_WIDTH-1:0] r_tdest;
  logic [W-1:0]               r_tdata;
  logic [KW-1:0]              r_tkeep;
  logic                       r_tlast;
  logic                       r_tvalid;
  logic                       r_busy;
  logic                       r_done;
  logic [CNT_WIDTH-1:0]       r_tx_cnt;

  // Checker state
  logic [15:0]                r_c_beat;
  logic [15:0]                r_c_q;
  logic [15:0]                r_c_exp;
  logic                       r_c_err;
  logic [CNT_WIDTH-1:0]       r_rx_cnt;
  logic [CNT_WIDTH-1:0]       r_drop_cnt;
  logic [CNT_WIDTH-1:0]       r_err_cnt;

  logic                       w_start_ok;
  logic                       w_cfg_ok;
  logic                       w_gen_hs;
  logic [15:0]                w_in_beats;
  logic [KW-1:0]              w_in_keep;
  logic [CNT_WIDTH-1:0]       w_pkt_next;
  logic [15:0]                w_beat_next;
  logic                       w_chk_hs;
  logic                       w_c_first;
  logic [15:0]                w_c_q;
  logic [15:0]                w_c_diff;
  logic                       w_c_ahead;
  logic                       w_c_behind;
  logic                       w_c_lastpos;
  logic                       w_c_beat_err;
  logic                       w_c_pkt_err;
  logic [CNT_WIDTH:0]         w_drop_sum;
  logic                       w_unused;

  // A start is only honoured from IDLE; a zero field turns it into a clear-and-done.
  assign w_start_ok  = i_start && (r_state == S_IDLE);
  assign w_cfg_ok    = (i_num_packets != '0) && (i_pkt_beats != '0);
  assign w_gen_hs    = r_tvalid && gen.tready;
  assign w_in_beats  = 16'(i_pkt_beats);
  assign w_in_keep   = (i_last_keep == '0) ? '1 : i_last_keep;
  assign w_pkt_next  = r_pkt + CNT_ONE;
  assign w_beat_next = r_beat + 16'd1;

  // Generator FSM; every stream output is registered and only changes on a handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_pkt       <= '0;
      r_beats     <= '0;
      r_beat      <= '0;
      r_last_keep <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_tdest     <= '0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tx_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_tx_cnt <= '0;
            if (w_cfg_ok) begin
              r_state     <= S_SEND;
              r_busy      <= 1'b1;
              r_num       <= i_num_packets;
              r_beats     <= w_in_beats;
              r_last_keep <= w_in_keep;
              r_gap       <= i_gap_cycles;
              r_tdest     <= i_cfg_tdest;
              r_pkt       <= '0;
              r_beat      <= '0;
              r_tvalid    <= 1'b1;
              r_tdata     <= f_pattern(16'd0, 16'd0);
              r_tlast     <= (w_in_beats == 16'd1);
              r_tkeep     <= f_keep(w_in_beats == 16'd1, w_in_keep);
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (w_gen_hs) begin
            if (r_tlast) begin
              r_tx_cnt <= f_sat_inc(r_tx_cnt);
              r_pkt    <= w_pkt_next;
              r_beat   <= '0;
              if (r_pkt == r_num - CNT_ONE) begin
                r_state  <= S_IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end else if (r_gap == 8'd0) begin
                r_tdata <= f_pattern(w_pkt_next[15:0], 16'd0);
                r_tlast <= (r_beats == 16'd1);
                r_tkeep <= f_keep(r_beats == 16'd1, r_last_keep);
              end else begin
                r_state   <= S_GAP;
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_gap_cnt <= r_gap;
              end
            end else begin
              r_beat  <= w_beat_next;
              r_tdata <= f_pattern(r_pkt[15:0], w_beat_next);
              r_tlast <= (w_beat_next == r_beats - 16'd1);
              r_tkeep <= f_keep(w_beat_next == r_beats - 16'd1, r_last_keep);
            end
          end
        end
        S_GAP: begin
          // r_gap_cnt runs gap..1, giving exactly gap idle cycles.
          if (r_gap_cnt == 8'd1) begin
            r_state  <= S_SEND;
            r_tvalid <= 1'b1;
            r_tdata  <= f_pattern(r_pkt[15:0], 16'd0);
            r_tlast  <= (r_beats == 16'd1);
            r_tkeep  <= f_keep(r_beats == 16'd1, r_last_keep);
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gen.tdata  = r_tdata;
  assign gen.tkeep  = r_tkeep;
  assign gen.tid    = {AXIS_ID_WIDTH{1'b0}};
  assign gen.tdest  = r_tdest;
  assign gen.tlast  = r_tlast;
  assign gen.tvalid = r_tvalid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

  // The checker never back-pressures, so every valid beat is a handshake.
  assign chk.tready = 1'b1;
  assign w_chk_hs   = chk.tvalid;
  assign w_unused   = ^{chk.tid, chk.tdest};

  assign w_c_first    = (r_c_beat == 16'd0);
  assign w_c_q        = w_c_first ? chk.tdata[31:16] : r_c_q;
  // Modular distance from the expected index: top bit set means the packet is from the past.
  assign w_c_diff     = w_c_q - r_c_exp;
  assign w_c_ahead    = w_c_first && (w_c_diff != 16'd0) && !w_c_diff[15];
  assign w_c_behind   = w_c_first && w_c_diff[15];
  assign w_c_lastpos  = (r_c_beat == r_beats - 16'd1);
  assign w_c_beat_err = (chk.tdata[15:0] != r_c_beat) ||
                        (chk.tdata[31:16] != w_c_q) ||
                        ((chk.tdata & ~LOW_MASK) != '0) ||
                        (chk.tkeep != f_keep(w_c_lastpos, r_last_keep)) ||
                        (chk.tlast != w_c_lastpos);
  assign w_c_pkt_err  = r_c_err || w_c_behind || w_c_beat_err;
  assign w_drop_sum   = {1'b0, r_drop_cnt} + (CNT_WIDTH+1)'(w_c_diff);

  // Checker: per-beat pattern verification, drop inference and per-packet accounting.
  always_ff @(posedge aclk) begin
    if (!aresetn || w_start_ok) begin
      r_c_beat   <= '0;
      r_c_q      <= '0;
      r_c_exp    <= '0;
      r_c_err    <= 1'b0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_chk_hs) begin
      if (w_c_ahead) begin
        r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
      end
      r_c_q <= w_c_q;
      if (chk.tlast) begin
        r_rx_cnt <= f_sat_inc(r_rx_cnt);
        if (w_c_pkt_err) begin
          r_err_cnt <= f_sat_inc(r_err_cnt);
        end
        r_c_exp  <= w_c_q + 16'd1;
        r_c_beat <= '0;
        r_c_err  <= 1'b0;
      end else begin
        if (r_c_beat != 16'hFFFF) begin
          r_c_beat <= r_c_beat + 16'd1;
        end
        r_c_err <= w_c_pkt_err;
      end
    end
  end

  assign o_tx_pkt_count  = r_tx_cnt;
  assign o_rx_pkt_count  = r_rx_cnt;
  assign o_rx_drop_count = r_drop_cnt;
  assign o_rx_err_count  = r_err_cnt;
endmodule
